// File: rtl/ctrl_if.sv
// Byte link between the control-SPI shifter and the command decoder.
// master = SPI side, slave = decoder side.
interface ctrl_if;
  logic [7:0] ctrl_data;
  logic       ctrl_dvld;
  logic [7:0] ctrl_q;
  logic       ctrl_qvld;

  modport master (
    output ctrl_data,
    output ctrl_dvld,
    input  ctrl_q,
    input  ctrl_qvld
  );

  modport slave (
    input  ctrl_data,
    input  ctrl_dvld,
    output ctrl_q,
    output ctrl_qvld
  );
endinterface

// File: rtl/ctrl_cmd_dec.sv
// Control-SPI command decoder and config register bank.
// 1-byte reads, 2-byte writes, status/ID readback, error counter.
module ctrl_cmd_dec #(
  parameter int         NREG    = 16,
  parameter int         TIMEOUT = 1024,
  parameter logic [7:0] ID_VAL  = 8'hA5
) (
  input  logic             clk_sys,
  input  logic             rst,
  ctrl_if.slave            bus,
  output logic             reg_wr,
  output logic [6:0]       reg_addr,
  output logic [7:0]       reg_wdata,
  output logic [NREG*8-1:0] cfg_regs,
  input  logic [63:0]      stat_in,
  output logic [7:0]       err_cnt
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    WDATA,
    RESP
  } state_t;

  state_t      state, nxt;
  logic [6:0]  addr_q;
  logic [TW-1:0] timer;
  logic        q_pend;
  logic [7:0]  q_data;

  logic        addr_hit;
  logic [7:0]  rd_val;
  logic        rd_bad;
  logic        ld_addr;
  logic        tmr_clr;
  logic        tmr_inc;
  logic        wr_cfg;
  logic        q_ld;
  logic [1:0]  err_inc;
  logic        err_clr;
  logic [9:0]  err_sum;

  assign addr_hit = (addr_q < 7'(NREG));
  assign err_sum  = {2'b00, err_cnt} + {8'h00, err_inc};

  // Read mux; config decode wins over the status window.
  always_comb begin
    rd_val = 8'h00;
    rd_bad = 1'b0;
    if (addr_hit)
      rd_val = cfg_regs[{addr_q, 3'b000} +: 8];
    else if (addr_q[6:3] == 4'b1000)
      rd_val = stat_in[{addr_q[2:0], 3'b000} +: 8];
    else if (addr_q == 7'h7F)
      rd_val = ID_VAL;
    else
      rd_bad = 1'b1;
  end

  // State register.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // Next state and datapath controls.
  always_comb begin
    nxt     = state;
    ld_addr = 1'b0;
    tmr_clr = 1'b0;
    tmr_inc = 1'b0;
    wr_cfg  = 1'b0;
    q_ld    = 1'b0;
    err_inc = 2'd0;
    err_clr = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.ctrl_dvld) begin
          ld_addr = 1'b1;
          if (bus.ctrl_data[7]) begin
            tmr_clr = 1'b1;
            nxt     = WDATA;
          end else begin
            nxt = RESP;
          end
        end
      end
      RESP: begin
        q_ld    = 1'b1;
        nxt     = IDLE;
        err_inc = {1'b0, rd_bad} + {1'b0, bus.ctrl_dvld};
      end
      WDATA: begin
        if (bus.ctrl_dvld) begin
          nxt = IDLE;
          if (addr_hit)               wr_cfg  = 1'b1;
          else if (addr_q == 7'h7E)   err_clr = 1'b1;
          else                        err_inc = 2'd1;
        end else if (timer == T_LAST) begin
          nxt     = IDLE;
          err_inc = 2'd1;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  // Datapath: address, timer, response pipe, write commit, errors.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      addr_q        <= '0;
      timer         <= '0;
      q_pend        <= 1'b0;
      q_data        <= '0;
      bus.ctrl_q    <= '0;
      bus.ctrl_qvld <= 1'b0;
      reg_wr        <= 1'b0;
      reg_addr      <= '0;
      reg_wdata     <= '0;
      cfg_regs      <= '0;
      err_cnt       <= '0;
    end else begin
      if (ld_addr) addr_q <= bus.ctrl_data[6:0];
      if (tmr_clr)      timer <= '0;
      else if (tmr_inc) timer <= timer + 1'b1;
      q_pend <= q_ld;
      if (q_ld) q_data <= rd_val;
      bus.ctrl_qvld <= q_pend;
      if (q_pend) bus.ctrl_q <= q_data;
      reg_wr <= wr_cfg;
      if (wr_cfg) begin
        reg_addr                      <= addr_q;
        reg_wdata                     <= bus.ctrl_data;
        cfg_regs[{addr_q, 3'b000} +: 8] <= bus.ctrl_data;
      end
      if (err_clr)
        err_cnt <= '0;
      else if (err_sum > 10'd255)
        err_cnt <= 8'hFF;
      else
        err_cnt <= err_sum[7:0];
    end
  end

endmodule

// File: tb/tb_ctrl_cmd_dec.sv
// Directed bench for ctrl_cmd_dec.
// Hand-computed expectations, one check task.
module tb_ctrl_cmd_dec;
  localparam int NREG    = 16;
  localparam int TIMEOUT = 1024;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              reg_wr;
  logic [6:0]        reg_addr;
  logic [7:0]        reg_wdata;
  logic [NREG*8-1:0] cfg_regs;
  logic [63:0]       stat_in = '0;
  logic [7:0]        err_cnt;
  int                n_chk = 0;
  int                n_err = 0;
  int                wr_cnt = 0;
  int                wr_base;

  ctrl_if bus ();

  ctrl_cmd_dec #(.NREG(NREG), .TIMEOUT(TIMEOUT), .ID_VAL(8'hA5)) dut (
    .clk_sys  (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .reg_wr   (reg_wr),
    .reg_addr (reg_addr),
    .reg_wdata(reg_wdata),
    .cfg_regs (cfg_regs),
    .stat_in  (stat_in),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (reg_wr === 1'b1) wr_cnt++;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    bus.ctrl_data = b;
    bus.ctrl_dvld = 1'b1;
    @(posedge clk); #1;
    bus.ctrl_dvld = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_read(input string tag, input logic [7:0] cmd,
                         input logic [7:0] exp);
    send(cmd);
    chk({tag, "_qv_k"}, bus.ctrl_qvld, 1'b0);
    idle(1);
    chk({tag, "_qv_k1"}, bus.ctrl_qvld, 1'b0);
    idle(1);
    chk({tag, "_qv_k2"}, bus.ctrl_qvld, 1'b1);
    chk({tag, "_q"}, bus.ctrl_q, exp);
    idle(1);
    chk({tag, "_qv_k3"}, bus.ctrl_qvld, 1'b0);
    chk({tag, "_qhold"}, bus.ctrl_q, exp);
  endtask

  initial begin
    bus.ctrl_data = '0;
    bus.ctrl_dvld = 1'b0;
    idle(2);
    rst = 1'b0;
    idle(1);

    chk("rst_q", bus.ctrl_q, 8'h00);
    chk("rst_qv", bus.ctrl_qvld, 1'b0);
    chk("rst_wr", reg_wr, 1'b0);
    chk("rst_err", err_cnt, 8'h00);
    chk("rst_cfg", cfg_regs, '0);

    send(8'h83);
    send(8'h5A);
    chk("w3_wr", reg_wr, 1'b1);
    chk("w3_addr", reg_addr, 7'h03);
    chk("w3_data", reg_wdata, 8'h5A);
    chk("w3_cfg", cfg_regs[31:24], 8'h5A);
    idle(1);
    chk("w3_wr_off", reg_wr, 1'b0);

    do_read("r03", 8'h03, 8'h5A);
    do_read("r7f", 8'h7F, 8'hA5);
    stat_in = 64'h0000_0000_0000_BE00;
    do_read("r41", 8'h41, 8'hBE);
    chk("r_err", err_cnt, 8'h00);

    wr_base = wr_cnt;
    send(8'h85);
    idle(TIMEOUT);
    chk("to_err", err_cnt, 8'h01);
    chk("to_nowr", wr_cnt, wr_base);
    do_read("to_r05", 8'h05, 8'h00);
    chk("to_err2", err_cnt, 8'h01);

    send(8'h84);
    idle(TIMEOUT - 1);
    send(8'h77);
    chk("edge_wr", reg_wr, 1'b1);
    chk("edge_cfg", cfg_regs[39:32], 8'h77);
    idle(1);
    chk("edge_err", err_cnt, 8'h01);

    wr_base = wr_cnt;
    send(8'hC0);
    send(8'h11);
    idle(1);
    chk("ro_err", err_cnt, 8'h02);
    send(8'hFE);
    send(8'h00);
    idle(1);
    chk("clr_err", err_cnt, 8'h00);
    chk("ro_nowr", wr_cnt, wr_base);

    send(8'h03);
    send(8'h10);
    idle(1);
    chk("drop_qv", bus.ctrl_qvld, 1'b1);
    chk("drop_q", bus.ctrl_q, 8'h5A);
    idle(2);
    chk("drop_qv2", bus.ctrl_qvld, 1'b0);
    chk("drop_err", err_cnt, 8'h01);

    wr_base = wr_cnt;
    for (int i = 0; i < 300; i++) begin
      send(8'h20);
      idle(3);
    end
    chk("sat_err", err_cnt, 8'hFF);
    chk("sat_q", bus.ctrl_q, 8'h00);
    chk("sat_nowr", wr_cnt, wr_base);

    send(8'h81);
    idle(3);
    rst = 1'b1;
    #1;
    chk("mid_err", err_cnt, 8'h00);
    chk("mid_cfg", cfg_regs, '0);
    chk("mid_addr", reg_addr, 7'h00);
    chk("mid_wd", reg_wdata, 8'h00);
    chk("mid_q", bus.ctrl_q, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    idle(1);
    send(8'h82);
    send(8'h33);
    chk("post_wr", reg_wr, 1'b1);
    chk("post_addr", reg_addr, 7'h02);
    chk("post_cfg", cfg_regs[23:16], 8'h33);
    chk("post_cfg1", cfg_regs[15:8], 8'h00);
    chk("post_err", err_cnt, 8'h00);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
